// File: rtl/iterative_divider.sv
// Multi-cycle signed divider: restoring shift-subtract, one quotient bit per cycle,
// fixed latency regardless of operands (including divide-by-zero and overflow).

module add_sub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b ^ {WIDTH{sub}}} + {{WIDTH{1'b0}}, sub};
endmodule

module iterative_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic             sign_q;
  logic             sign_r;
  logic             dz;
  logic             ov;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             no_borrow;

  assign abs_a = data_operandA[WIDTH-1] ? ('0 - data_operandA) : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? ('0 - data_operandB) : data_operandB;

  // Shifted partial remainder is WIDTH+1 bits; its top bit set means it already
  // exceeds any divisor, so no-borrow is that bit OR the WIDTH-bit subtract carry.
  assign rem_shift = {rem, dvd[WIDTH-1]};
  assign no_borrow = rem_shift[WIDTH] | carry;

  add_sub #(.WIDTH(WIDTH)) u_sub (
    .a         (rem_shift[WIDTH-1:0]),
    .b         (dsr),
    .sub       (1'b1),
    .sum       (diff),
    .carry_out (carry)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      rem            <= '0;
      dvd            <= '0;
      dsr            <= '0;
      sign_q         <= 1'b0;
      sign_r         <= 1'b0;
      dz             <= 1'b0;
      ov             <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          // The RDY cycle still counts as busy, so a start is only taken after it.
          if (data_resultRDY) begin
            busy <= 1'b0;
          end else if (ctrl_DIV) begin
            dvd    <= abs_a;
            dsr    <= abs_b;
            rem    <= '0;
            count  <= '0;
            sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            sign_r <= data_operandA[WIDTH-1];
            dz     <= (data_operandB == '0);
            ov     <= (data_operandA == MIN_VAL) && (data_operandB == '1);
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          rem   <= no_borrow ? diff : rem_shift[WIDTH-1:0];
          dvd   <= {dvd[WIDTH-2:0], no_borrow};
          count <= count + 1'b1;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          if (sign_q) dvd <= '0 - dvd;
          if (sign_r) rem <= '0 - rem;
          state <= DONE;
        end
        DONE: begin
          if (dz) begin
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b1;
          end else if (ov) begin
            data_result    <= MIN_VAL;
            data_remainder <= '0;
            data_exception <= 1'b1;
          end else begin
            data_result    <= dvd;
            data_remainder <= rem;
            data_exception <= 1'b0;
          end
          data_resultRDY <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_divider.sv
// Directed-vector and random checks of iterative_divider: results, latency, RDY pulse,
// busy window, ignored re-starts and mid-operation reset.

module tb_iterative_divider;
  localparam int unsigned W = 32;
  localparam int LAT = W + 2;

  logic          clock;
  logic          reset;
  logic          ctrl_DIV;
  logic [W-1:0]  data_operandA;
  logic [W-1:0]  data_operandB;
  logic [W-1:0]  data_result;
  logic [W-1:0]  data_remainder;
  logic          data_exception;
  logic          data_resultRDY;
  logic          busy;

  iterative_divider #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int rdy_pulses = 0;

  always @(negedge clock) if (data_resultRDY) rdy_pulses++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        exc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends the RDY cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int repulse,
                       output logic [31:0] q, output logic [31:0] r, output logic exc,
                       output int lat, output bit busy_ok, output bit hold_ok,
                       output bit pulse_ok);
    logic [31:0] prev_q;
    logic [31:0] prev_r;
    prev_q = data_result;
    prev_r = data_remainder;
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    data_operandA = ~a;
    data_operandB = b + 32'd3;
    busy_ok = busy;
    hold_ok = 1'b1;
    lat = 0;
    while (lat < 200) begin
      if (repulse != 0 && lat == repulse) begin
        ctrl_DIV = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
      end else begin
        ctrl_DIV = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
      if (data_resultRDY) break;
      if (!busy) busy_ok = 1'b0;
      if (data_result !== prev_q || data_remainder !== prev_r) hold_ok = 1'b0;
    end
    ctrl_DIV = 1'b0;
    if (!busy) busy_ok = 1'b0;
    q = data_result;
    r = data_remainder;
    exc = data_exception;
    @(posedge clock); #1;
    pulse_ok = !data_resultRDY && !busy;
  endtask

  logic [31:0] q, r, ea, eb;
  logic        exc;
  int          lat, p0;
  bit          busy_ok, hold_ok, pulse_ok;

  initial begin
    vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};
    vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{32'h00001234, 32'd0,        32'd0,        32'd0,        1'b1};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b1};
    vecs[6]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0};
    vecs[7]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
    vecs[8]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0};
    vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0};
    vecs[10] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFF, 1'b0};

    reset = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_remainder", data_remainder, 32'd0);
    check("reset_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, 0, q, r, exc, lat, busy_ok, hold_ok, pulse_ok);
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_r", i), r, vecs[i].r);
      check($sformatf("vec%0d_exc", i), {31'd0, exc}, {31'd0, vecs[i].exc});
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_busy", i), {31'd0, busy_ok}, 32'd1);
      check($sformatf("vec%0d_hold", i), {31'd0, hold_ok}, 32'd1);
      check($sformatf("vec%0d_pulse", i), {31'd0, pulse_ok}, 32'd1);
    end

    // Re-pulse mid-RUN must not restart; then back-to-back start right after RDY.
    p0 = rdy_pulses;
    do_op(32'd100, 32'd7, 5, q, r, exc, lat, busy_ok, hold_ok, pulse_ok);
    check("repulse_q", q, 32'd14);
    check("repulse_r", r, 32'd2);
    check("repulse_latency", lat, LAT);
    do_op(32'd7, 32'd2, 0, q, r, exc, lat, busy_ok, hold_ok, pulse_ok);
    check("b2b_q", q, 32'd3);
    check("b2b_r", r, 32'd1);
    check("b2b_latency", lat, LAT);
    check("rdy_pulse_count", rdy_pulses - p0, 32'd2);

    // Reset in the middle of RUN.
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("midrun_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    check("midreset_result", data_result, 32'd0);
    check("midreset_remainder", data_remainder, 32'd0);
    check("midreset_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    p0 = rdy_pulses;
    repeat (45) @(posedge clock);
    #1;
    check("midreset_no_rdy", rdy_pulses - p0, 32'd0);
    do_op(32'd9, 32'd4, 0, q, r, exc, lat, busy_ok, hold_ok, pulse_ok);
    check("after_reset_q", q, 32'd2);
    check("after_reset_r", r, 32'd1);

    for (int i = 0; i < 1000; i++) begin
      ea = $urandom;
      if (i % 2 == 0) eb = $urandom;
      else eb = (i % 4 == 1) ? 32'($urandom_range(1, 1000)) : ('0 - 32'($urandom_range(1, 1000)));
      if (eb == 32'd0) eb = 32'd1;
      if (ea == 32'h80000000 && eb == 32'hFFFFFFFF) eb = 32'd1;
      do_op(ea, eb, 0, q, r, exc, lat, busy_ok, hold_ok, pulse_ok);
      check($sformatf("rand%0d_q a=%h b=%h", i, ea, eb), q, 32'($signed(ea) / $signed(eb)));
      check($sformatf("rand%0d_r a=%h b=%h", i, ea, eb), r, 32'($signed(ea) % $signed(eb)));
      check($sformatf("rand%0d_exc", i), {31'd0, exc}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
